// File: rtl/ps2_rx_mio_pkg.sv
// Shared constants for the PS/2 keyboard receiver: FSM encoding, status-word
// field positions, MIO address, and the odd-parity helper.
package ps2_rx_mio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam int DOUT_HEAD_LSB  = 0;
  localparam int DOUT_VALID_BIT = 8;
  localparam int DOUT_OVF_BIT   = 9;
  localparam int DOUT_FERR_BIT  = 10;
  localparam int DOUT_CNT_LSB   = 12;

  localparam logic [31:0] PS2_MIO_ADDR = 32'hFFFF_F100;

  // A device frame is good when data plus parity carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_mio_if.sv
// MIO read-side bus of the PS/2 receiver: pop strobe, status word, interrupt.
interface ps2_rx_mio_if;
  logic        rd;
  logic [31:0] dout;
  logic        irq;

  modport master (output rd, input dout, input irq);
  modport slave  (input rd, output dout, output irq);
endinterface

// File: rtl/ps2_rx_mio_fifo.sv
// Byte FIFO for received scan codes; same-cycle push and pop are allowed,
// including when full, so a pop makes room for the concurrent push.
module ps2_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       i_push,
  input  logic [DATA_W-1:0]          i_din,
  input  logic                       i_pop,
  output logic [DATA_W-1:0]          o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rptr];
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/ps2_rx_mio.sv
// PS/2 host receiver on the MIO bus: synchronizes the pad pair, deframes
// device frames and queues bytes. Define PS2_PARITY_CHECK_EN to reject bad parity.
module ps2_rx_mio
  import ps2_rx_mio_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic          clk,
  input  logic          RSTN,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  ps2_rx_mio_if.slave   bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

  logic [2:0]       r_kclk;
  logic [1:0]       r_kdat;
  logic             w_fe;
  logic             w_bit;
  ps2_state_e       r_state;
  ps2_state_e       w_state_nxt;
  logic [2:0]       r_bitcnt;
  logic [TO_W-1:0]  r_tcnt;
  logic [7:0]       r_shift;
  logic             w_tmo;
  logic             w_shift_en;
  logic             w_push;
  logic             w_ferr_set;
  logic             w_par_ok;
  logic             w_pop;
  logic             w_valid;
  logic             w_full;
  logic             w_empty;
  logic [7:0]       w_head;
  logic [CNT_W-1:0] w_count;
  logic             r_ovf;
  logic             r_ferr;
  logic             r_irq;
  logic [31:0]      w_dout;

  // Pad synchronizers idle high; the third clock flop yields the falling edge.
  always_ff @(posedge clk) begin
    if (!RSTN) begin
      r_kclk <= 3'b111;
      r_kdat <= 2'b11;
    end else begin
      r_kclk <= {r_kclk[1:0], ps2_clk};
      r_kdat <= {r_kdat[0], ps2_data};
    end
  end

  assign w_fe  = r_kclk[2] & ~r_kclk[1];
  assign w_bit = r_kdat[1];
  assign w_tmo = (r_tcnt == TO_W'(TIMEOUT_CYCLES - 1));

`ifdef PS2_PARITY_CHECK_EN
  logic r_par;
  always_ff @(posedge clk) begin
    if ((r_state == ST_PARITY) && w_fe) r_par <= w_bit;
  end
  assign w_par_ok = odd_parity_ok(r_shift, r_par);
`else
  assign w_par_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!RSTN) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_en  = 1'b0;
    w_push      = 1'b0;
    w_ferr_set  = 1'b0;
    case (r_state)
      ST_IDLE:   if (w_fe && !w_bit) w_state_nxt = ST_DATA;
      ST_DATA:   if (w_fe) begin
                   w_shift_en = 1'b1;
                   if (r_bitcnt == 3'd7) w_state_nxt = ST_PARITY;
                 end
      ST_PARITY: if (w_fe) w_state_nxt = ST_STOP;
      ST_STOP:   if (w_fe) begin
                   w_state_nxt = ST_IDLE;
                   if (w_bit && w_par_ok) w_push = 1'b1;
                   else                   w_ferr_set = 1'b1;
                 end
      default:   w_state_nxt = ST_IDLE;
    endcase
    // A stalled device abandons the frame; an edge in this cycle restarts the count instead.
    if ((r_state != ST_IDLE) && !w_fe && w_tmo) begin
      w_state_nxt = ST_IDLE;
      w_ferr_set  = 1'b1;
      w_push      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!RSTN) begin
      r_bitcnt <= '0;
      r_tcnt   <= '0;
    end else if (r_state == ST_IDLE) begin
      r_bitcnt <= '0;
      r_tcnt   <= '0;
    end else begin
      if (w_shift_en) r_bitcnt <= r_bitcnt + 3'd1;
      if (w_fe)        r_tcnt <= '0;
      else if (!w_tmo) r_tcnt <= r_tcnt + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_shift_en) r_shift <= {w_bit, r_shift[7:1]};
  end

  ps2_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(8)) u_fifo (
    .clk     (clk),
    .rstn    (RSTN),
    .i_push  (w_push),
    .i_din   (r_shift),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_valid = ~w_empty;
  assign w_pop   = bus.rd & w_valid;

  // Stickies: any read clears them, but a set in the same cycle wins.
  always_ff @(posedge clk) begin
    if (!RSTN) begin
      r_ovf  <= 1'b0;
      r_ferr <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      else if (bus.rd)                r_ovf <= 1'b0;
      if (w_ferr_set)                 r_ferr <= 1'b1;
      else if (bus.rd)                r_ferr <= 1'b0;
      r_irq <= w_valid;
    end
  end

  always_comb begin
    w_dout = '0;
    w_dout[DOUT_HEAD_LSB +: 8] = w_valid ? w_head : 8'h00;
    w_dout[DOUT_VALID_BIT]     = w_valid;
    w_dout[DOUT_OVF_BIT]       = r_ovf;
    w_dout[DOUT_FERR_BIT]      = r_ferr;
    w_dout[DOUT_CNT_LSB +: 4]  = 4'(w_count);
  end

  assign bus.dout = w_dout;
  assign bus.irq  = r_irq;

endmodule

// File: tb/tb_ps2_rx_mio.sv
// Directed bench for ps2_rx_mio with a short bit period and timeout.
`timescale 1ns/1ps
module tb_ps2_rx_mio;
  localparam int HALF = 20;
  localparam int TMO  = 100;

  logic clk = 1'b0;
  logic RSTN = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;

  ps2_rx_mio_if bus();

  ps2_rx_mio #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk      (clk),
    .RSTN     (RSTN),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic good_par(input logic [7:0] b);
    return ~^b;
  endfunction

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    cyc(HALF);
    ps2_clk = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic frame_head(input logic [7:0] b, input logic par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
  endtask

  // Stop bit; optionally strobe rd on the very edge that consumes the stop fe.
  task automatic frame_stop(input logic stop, input bit pop_at_stop);
    ps2_data = stop;
    cyc(HALF);
    ps2_clk = 1'b0;
    if (pop_at_stop) begin
      cyc(2);
      bus.rd = 1'b1;
      cyc(1);
      bus.rd = 1'b0;
      cyc(HALF - 3);
    end else begin
      cyc(HALF);
    end
    ps2_clk = 1'b1;
    cyc(HALF);
  endtask

  task automatic send_frame(input logic [7:0] b);
    frame_head(b, good_par(b));
    frame_stop(1'b1, 1'b0);
  endtask

  task automatic pop(input string tag, input logic [7:0] exp);
    check(tag, {23'b0, bus.dout[8:0]}, {23'b0, 1'b1, exp});
    bus.rd = 1'b1;
    cyc(1);
    bus.rd = 1'b0;
  endtask

  task automatic strobe_rd();
    bus.rd = 1'b1;
    cyc(1);
    bus.rd = 1'b0;
  endtask

  initial begin
    int lat;
    bus.rd = 1'b0;
    cyc(3);
    check("rst_dout", bus.dout, 32'h0);
    check("rst_irq", {31'b0, bus.irq}, 32'h0);
    RSTN = 1'b1;
    cyc(5);

    // Idle edge with data high is not a start bit
    ps2_bit(1'b1);
    cyc(5);
    check("idle_fe", bus.dout, 32'h0);

    // Good frame 0x1C with latency from the stop-bit pad edge
    frame_head(8'h1C, 1'b0);
    ps2_data = 1'b1;
    cyc(HALF);
    ps2_clk = 1'b0;
    lat = 0;
    while (!bus.dout[8] && lat < 10) begin
      cyc(1);
      lat++;
    end
    check("good_lat", 32'(lat), 32'd3);
    check("good_irq_lag", {31'b0, bus.irq}, 32'h0);
    cyc(1);
    check("good_irq", {31'b0, bus.irq}, 32'h1);
    check("good_word", bus.dout, 32'h0000_111C);
    cyc(HALF - 5);
    ps2_clk = 1'b1;
    cyc(HALF);
    strobe_rd();
    check("good_pop_dout", bus.dout, 32'h0);
    cyc(1);
    check("good_pop_irq", {31'b0, bus.irq}, 32'h0);

    // Wrong parity bit
    frame_head(8'h1C, 1'b1);
    frame_stop(1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    check("par_err", bus.dout, 32'h0000_0400);
`else
    check("par_ignored", bus.dout, 32'h0000_111C);
`endif
    strobe_rd();
    check("par_clear", bus.dout, 32'h0);

    // Bad stop bit is always a frame error
    frame_head(8'h2B, good_par(8'h2B));
    frame_stop(1'b0, 1'b0);
    check("stop_err", bus.dout, 32'h0000_0400);
    strobe_rd();
    check("stop_clear", bus.dout, 32'h0);

    // Overflow: nine frames, no reads
    for (int i = 1; i <= 9; i++) send_frame(8'(i));
    check("ovf_word", bus.dout, 32'h0000_8301);
    pop("ovf_pop1", 8'h01);
    check("ovf_cleared", bus.dout, 32'h0000_7102);
    for (int i = 2; i <= 8; i++) pop("ovf_pop", 8'(i));
    check("ovf_empty", bus.dout, 32'h0);

    // Simultaneous push and pop with the FIFO full
    for (int i = 0; i < 8; i++) send_frame(8'(8'h10 + i));
    check("sim_full", bus.dout, 32'h0000_8110);
    frame_head(8'h18, good_par(8'h18));
    frame_stop(1'b1, 1'b1);
    check("sim_word", bus.dout, 32'h0000_8111);
    for (int i = 1; i <= 8; i++) pop("sim_pop", 8'(8'h10 + i));
    check("sim_empty", bus.dout, 32'h0);

    // Timeout after start plus four data bits
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_data = 1'b1;
    cyc(TMO + 20);
    check("tmo_err", bus.dout, 32'h0000_0400);
    send_frame(8'h5A);
    check("tmo_next", bus.dout, 32'h0000_155A);
    pop("tmo_pop", 8'h5A);
    check("tmo_clear", bus.dout, 32'h0);

    // Reset mid-frame drops the queued byte and the partial frame
    send_frame(8'h33);
    check("rmf_pre", bus.dout, 32'h0000_1133);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b0);
    ps2_data = 1'b1;
    RSTN = 1'b0;
    cyc(1);
    RSTN = 1'b1;
    check("rmf_dout", bus.dout, 32'h0);
    check("rmf_irq", {31'b0, bus.irq}, 32'h0);
    cyc(HALF);
    send_frame(8'hF0);
    check("rmf_next", bus.dout, 32'h0000_11F0);
    check("rmf_next_irq", {31'b0, bus.irq}, 32'h1);
    pop("rmf_pop", 8'hF0);
    check("rmf_empty", bus.dout, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
